// File: rtl/gray_sobel_edge.sv
// Streaming 3x3 Sobel edge detector: two line buffers, a 3x3 window and a
// two-stage pipeline producing saturated |Gx|+|Gy| plus a thresholded flag.
module gray_sobel_edge #(
    parameter int         IMG_WIDTH  = 640,
    parameter int         IMG_HEIGHT = 480,
    parameter logic [7:0] THRESH     = 8'd128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_valid,
    input  logic       din_sof,
    input  logic [7:0] gray_data,
    output logic       dout_valid,
    output logic [7:0] edge_data,
    output logic       edge_bin,
    output logic       dout_eol
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          qual;

    // A start-of-frame pulse places the current pixel at (0,0) regardless of the counters.
    always_comb begin
        cur_col = din_sof ? '0 : col_q;
        cur_row = din_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (din_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    assign qual = (cur_row >= RW'(2)) && (cur_col >= CW'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    logic [7:0] lb1_mem [IMG_WIDTH];
    logic [7:0] lb2_mem [IMG_WIDTH];
    logic [7:0] lb1_rd, lb2_rd;

    assign lb1_rd = lb1_mem[cur_col];
    assign lb2_rd = lb2_mem[cur_col];

    always_ff @(posedge clk) begin
        if (din_valid) begin
            lb2_mem[cur_col] <= lb1_rd;
            lb1_mem[cur_col] <= gray_data;
        end
    end

    // win_q[row][col]: row 0 is oldest line, col 2 is the newest column.
    logic [2:0][2:0][7:0] win_q;
    logic [1:0]           vld_pipe_q;
    logic                 eol1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q      <= '0;
            vld_pipe_q <= '0;
            eol1_q     <= 1'b0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], din_valid & qual};
            if (din_valid) begin
                for (int i = 0; i < 3; i++) begin
                    win_q[i][0] <= win_q[i][1];
                    win_q[i][1] <= win_q[i][2];
                end
                win_q[0][2] <= lb2_rd;
                win_q[1][2] <= lb1_rd;
                win_q[2][2] <= gray_data;
                eol1_q      <= (cur_col == COL_LAST);
            end
        end
    end

    function automatic logic signed [10:0] sx(input logic [7:0] v);
        return signed'({3'b000, v});
    endfunction

    logic signed [10:0] gx, gy, ax, ay;
    logic        [11:0] mag;
    logic        [7:0]  sat;

    always_comb begin
        gx  = (sx(win_q[0][2]) + (sx(win_q[1][2]) <<< 1) + sx(win_q[2][2]))
            - (sx(win_q[0][0]) + (sx(win_q[1][0]) <<< 1) + sx(win_q[2][0]));
        gy  = (sx(win_q[2][0]) + (sx(win_q[2][1]) <<< 1) + sx(win_q[2][2]))
            - (sx(win_q[0][0]) + (sx(win_q[0][1]) <<< 1) + sx(win_q[0][2]));
        ax  = gx[10] ? -gx : gx;
        ay  = gy[10] ? -gy : gy;
        mag = {1'b0, ax} + {1'b0, ay};
        sat = (mag > 12'd255) ? 8'hFF : mag[7:0];
    end

    logic [7:0] edge_q;
    logic       bin_q, eol2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_q <= '0;
            bin_q  <= 1'b0;
            eol2_q <= 1'b0;
        end else if (vld_pipe_q[0]) begin
            edge_q <= sat;
            bin_q  <= (sat >= THRESH);
            eol2_q <= eol1_q;
        end
    end

    assign dout_valid = vld_pipe_q[1];
    assign edge_data  = edge_q;
    assign edge_bin   = bin_q;
    assign dout_eol   = vld_pipe_q[1] & eol2_q;

endmodule

// File: tb/tb_gray_sobel_edge.sv
// Directed bench for gray_sobel_edge on an 8x6 image; a second instance with
// THRESH=80 runs in parallel on the same stimulus.
module tb_gray_sobel_edge;
    localparam int W = 8;
    localparam int H = 6;
    localparam int NOUT = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din_valid = 1'b0;
    logic       din_sof = 1'b0;
    logic [7:0] gray_data = 8'd0;
    logic       dout_valid, edge_bin, dout_eol;
    logic [7:0] edge_data;
    logic       dv80, eb80, eol80;
    logic [7:0] ed80;

    gray_sobel_edge #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESH(8'd128)) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_sof(din_sof),
        .gray_data(gray_data), .dout_valid(dout_valid), .edge_data(edge_data),
        .edge_bin(edge_bin), .dout_eol(dout_eol));

    gray_sobel_edge #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESH(8'd80)) dut80 (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_sof(din_sof),
        .gray_data(gray_data), .dout_valid(dv80), .edge_data(ed80),
        .edge_bin(eb80), .dout_eol(eol80));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         obs_val[$];
    int         obs_bin[$];
    int         obs_b80[$];
    int         obs_eol[$];
    int         obs_cyc[$];
    int         trig[$];

    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            obs_val.push_back(int'(edge_data));
            obs_bin.push_back(int'(edge_bin));
            obs_b80.push_back(int'(eb80));
            obs_eol.push_back(int'(dout_eol));
            obs_cyc.push_back(cyc);
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        @(negedge clk);
        din_valid = v;
        din_sof   = s;
        gray_data = d;
    endtask

    // 0: uniform 255, 1: vertical step at col 4, 2: ramp 10*c, 3: uniform 0
    function automatic logic [7:0] pix(input int pat, input int r, input int c);
        int v;
        v = r * 0;
        case (pat)
            0: v = 255;
            1: v = (c >= 4) ? 255 : 0;
            2: v = 10 * c;
            default: v = 0;
        endcase
        return 8'(v);
    endfunction

    function automatic int exp_val(input int pat, input int i);
        int step_tab[6];
        step_tab = '{0, 0, 255, 255, 0, 0};
        case (pat)
            1: return step_tab[i % 6];
            2: return 80;
            default: return 0;
        endcase
    endfunction

    task automatic clear_obs();
        obs_val.delete(); obs_bin.delete(); obs_b80.delete();
        obs_eol.delete(); obs_cyc.delete(); trig.delete();
    endtask

    task automatic run_frame(input string nm, input int pat, input int max_gap, input bit use_sof);
        int ev;
        clear_obs();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive(1'b1, use_sof && r == 0 && c == 0, pix(pat, r, c));
                if (r >= 2 && c >= 2) trig.push_back(cyc);
                repeat ($urandom_range(max_gap, 0)) drive(1'b0, 1'b0, 8'($urandom));
            end
        end
        drive(1'b0, 1'b0, 8'd0);
        repeat (6) @(negedge clk);
        chk($sformatf("%s.cnt", nm), obs_val.size(), NOUT);
        for (int i = 0; i < NOUT; i++) begin
            if (i < obs_val.size()) begin
                ev = exp_val(pat, i);
                chk($sformatf("%s[%0d].val", nm, i), obs_val[i], ev);
                chk($sformatf("%s[%0d].bin", nm, i), obs_bin[i], int'(ev >= 128));
                chk($sformatf("%s[%0d].bin80", nm, i), obs_b80[i], int'(ev >= 80));
                chk($sformatf("%s[%0d].eol", nm, i), obs_eol[i], int'(i % 6 == 5));
                chk($sformatf("%s[%0d].lat", nm, i), obs_cyc[i], trig[i] + 2);
            end
        end
    endtask

    initial begin
        // Reset held while din_valid toggles with live data.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'(i % 2 == 0), 1'b0, 8'hAA);
            chk("rst.dv", int'(dout_valid), 0);
            chk("rst.data", int'(edge_data), 0);
            chk("rst.bin", int'(edge_bin), 0);
            chk("rst.eol", int'(dout_eol), 0);
        end
        chk("rst.nout", obs_val.size(), 0);
        @(negedge clk);
        rst = 1'b0;
        din_valid = 1'b0;
        repeat (2) @(negedge clk);

        run_frame("uni255", 0, 0, 1'b1);
        run_frame("vstep", 1, 0, 1'b1);
        run_frame("ramp", 2, 0, 1'b1);
        run_frame("vstep_gap", 1, 3, 1'b1);

        // Partial ramp frame of 15 pixels, then resync with din_sof.
        clear_obs();
        for (int i = 0; i < 15; i++) drive(1'b1, 1'(i == 0), pix(2, i / W, i % W));
        drive(1'b0, 1'b0, 8'd0);
        repeat (4) @(negedge clk);
        chk("resyncA.partial", obs_val.size(), 0);
        run_frame("resyncA", 3, 0, 1'b1);

        // Partial ramp frame; rst arrives with the 20th pixel, in-flight results dropped.
        clear_obs();
        for (int i = 0; i < 19; i++) drive(1'b1, 1'(i == 0), pix(2, i / W, i % W));
        drive(1'b1, 1'b0, pix(2, 19 / W, 19 % W));
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("resyncB.partial", obs_val.size(), 0);
        run_frame("resyncB", 3, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
